// File: rtl/ram_sp_clr.sv
// Single-port synchronous RAM with a hardware clear sweep and a 1- or 2-stage read pipeline.
// Accesses that arrive while the sweep owns the array are dropped and flagged on err.
module ram_sp_clr #(
  parameter int                  DATA_W   = 8,
  parameter int                  ADDR_W   = 10,
  parameter int                  READ_LAT = 1,
  parameter logic [DATA_W-1:0]   CLR_VAL  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clr,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              busy,
  output logic              err
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    S_CLEAR,
    S_READY
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;

  logic              accept;
  logic              rd_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              s0_valid;
  logic [DATA_W-1:0] s0_data;
  logic              err_q;

  // NOTE: every variable driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    unique case (state_q)
      S_CLEAR: begin
        if (clr) begin
          clr_ptr_d = '0;
        end else begin
          clr_ptr_d = clr_ptr_q + ADDR_W'(1);
          if (clr_ptr_q == {ADDR_W{1'b1}}) state_d = S_READY;
        end
      end
      S_READY: begin
        if (clr) begin
          state_d   = S_CLEAR;
          clr_ptr_d = '0;
        end
      end
      default: begin
        state_d   = S_CLEAR;
        clr_ptr_d = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_CLEAR;
      clr_ptr_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      err_q     <= cs && !accept;
    end
  end

  assign accept = cs && (state_q == S_READY) && !clr;
  assign rd_en  = accept && !wr;

  // A clr seen mid-sweep restarts the pointer instead of writing at that edge.
  assign mem_we = ((state_q == S_CLEAR) && !clr) || (accept && wr);
  assign mem_wa = (state_q == S_CLEAR) ? clr_ptr_q : addr;
  assign mem_wd = (state_q == S_CLEAR) ? CLR_VAL : data_in;

  // NOTE: the array has no reset; its contents are defined by the clear sweep, which keeps it mappable to RAM macros.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid <= 1'b0;
      s0_data  <= '0;
    end else begin
      s0_valid <= rd_en;
      if (rd_en) s0_data <= mem[addr];
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic              s1_valid;
      logic [DATA_W-1:0] s1_data;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s1_valid <= 1'b0;
          s1_data  <= '0;
        end else begin
          s1_valid <= s0_valid;
          if (s0_valid) s1_data <= s0_data;
        end
      end

      assign data_out = s1_data;
      assign rd_valid = s1_valid;
    end else begin : g_lat1
      assign data_out = s0_data;
      assign rd_valid = s0_valid;
    end
  endgenerate

  assign busy = (state_q == S_CLEAR);
  assign err  = err_q;

endmodule

// File: tb/tb_ram_sp_clr.sv
// Scoreboard bench for ram_sp_clr: instance a uses defaults, instance b uses READ_LAT=2, CLR_VAL=0x5A.
// Stimulus pushes expected reads/errors; a negedge monitor pops and compares whenever the DUTs respond.
module tb_ram_sp_clr;

  localparam int DEPTH = 1024;

  typedef struct packed {
    logic [7:0]  data;
    logic [31:0] due;
  } rd_exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      rst, cs, wr, clr;
  logic [1:0][9:0] addr;
  logic [1:0][7:0] din;

  logic [7:0] dout_a, dout_b;
  logic       rdv_a, rdv_b, busy_a, busy_b, err_a, err_b;

  logic [1:0][7:0] dout;
  logic [1:0]      rd_valid, busy, err;
  assign dout     = {dout_b, dout_a};
  assign rd_valid = {rdv_b, rdv_a};
  assign busy     = {busy_b, busy_a};
  assign err      = {err_b, err_a};

  ram_sp_clr dut_a (
    .clk(clk), .rst(rst[0]), .cs(cs[0]), .wr(wr[0]), .addr(addr[0]),
    .data_in(din[0]), .clr(clr[0]), .data_out(dout_a), .rd_valid(rdv_a),
    .busy(busy_a), .err(err_a)
  );

  ram_sp_clr #(.DATA_W(8), .ADDR_W(10), .READ_LAT(2), .CLR_VAL(8'h5A)) dut_b (
    .clk(clk), .rst(rst[1]), .cs(cs[1]), .wr(wr[1]), .addr(addr[1]),
    .data_in(din[1]), .clr(clr[1]), .data_out(dout_b), .rd_valid(rdv_b),
    .busy(busy_b), .err(err_b)
  );

  int          total = 0;
  int          bad   = 0;
  int          err_pend [2];
  logic [31:0] cyc = '0;
  rd_exp_t     q_a [$];
  rd_exp_t     q_b [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  // Called in the half-cycle before the accepting edge (cyc+1); the output register
  // is loaded READ_LAT-1 edges after acceptance and is seen at the following negedge.
  task automatic push_rd(input int d, input logic [7:0] v);
    rd_exp_t e;
    e.data = v;
    e.due  = cyc + 32'(lat(d));
    if (d == 0) q_a.push_back(e);
    else        q_b.push_back(e);
  endtask

  task automatic pop_rd(input int d, output rd_exp_t e, output bit ok);
    e  = '0;
    ok = 1'b0;
    if (d == 0) begin
      if (q_a.size() > 0) begin e = q_a.pop_front(); ok = 1'b1; end
    end else begin
      if (q_b.size() > 0) begin e = q_b.pop_front(); ok = 1'b1; end
    end
  endtask

  always @(negedge clk) begin
    rd_exp_t e;
    bit      ok;
    for (int d = 0; d < 2; d++) begin
      if (rd_valid[d]) begin
        pop_rd(d, e, ok);
        if (!ok) begin
          check($sformatf("unexpected_rd_valid_%0d", d), 64'(rd_valid[d]), 64'd0);
        end else begin
          check($sformatf("rd_data_%0d", d), 64'(dout[d]), 64'(e.data));
          check($sformatf("rd_cycle_%0d", d), 64'(cyc), 64'(e.due));
        end
      end
      if (err[d]) begin
        if (err_pend[d] == 0) check($sformatf("unexpected_err_%0d", d), 64'(err[d]), 64'd0);
        else err_pend[d]--;
      end
    end
  end

  task automatic step(input int d, input logic c_s, input logic w, input logic [9:0] a,
                      input logic [7:0] v, input logic c);
    @(negedge clk);
    cs[d]   = c_s;
    wr[d]   = w;
    addr[d] = a;
    din[d]  = v;
    clr[d]  = c;
  endtask

  task automatic rd(input int d, input logic [9:0] a, input logic [7:0] v);
    step(d, 1'b1, 1'b0, a, 8'h00, 1'b0);
    push_rd(d, v);
  endtask

  task automatic wrt(input int d, input logic [9:0] a, input logic [7:0] v);
    step(d, 1'b1, 1'b1, a, v, 1'b0);
  endtask

  task automatic idle(input int d);
    step(d, 1'b0, 1'b0, 10'd0, 8'h00, 1'b0);
  endtask

  // Counts rising edges until busy is seen low; inputs are idled after the first edge.
  task automatic wait_ready(input int d, output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
      cs[d]  = 1'b0;
      clr[d] = 1'b0;
    end while (busy[d] && n < 4 * DEPTH);
  endtask

  initial begin
    int n;
    rst = 2'b11; cs = '0; wr = '0; clr = '0; addr = '0; din = '0;
    err_pend[0] = 0;
    err_pend[1] = 0;

    #2;
    check("reset_data_out", 64'(dout[0]), 64'd0);
    check("reset_rd_valid", 64'(rd_valid[0]), 64'd0);
    check("reset_err", 64'(err[0]), 64'd0);
    check("reset_busy", 64'(busy[0]), 64'd1);

    // Reset sweep, then reads at the ends and middle of the array.
    @(negedge clk);
    rst[0] = 1'b0;
    wait_ready(0, n);
    check("busy_len_reset", 64'(n), 64'(DEPTH));
    rd(0, 10'd0, 8'h00);
    rd(0, 10'd511, 8'h00);
    rd(0, 10'd1023, 8'h00);
    idle(0);

    // Writes then back-to-back reads.
    wrt(0, 10'd2, 8'd4);
    wrt(0, 10'd12, 8'd10);
    rd(0, 10'd2, 8'd4);
    rd(0, 10'd12, 8'd10);
    idle(0);

    // Write attempted while the clr sweep owns the array.
    step(0, 1'b0, 1'b0, 10'd0, 8'h00, 1'b1);
    step(0, 1'b1, 1'b1, 10'd4, 8'd8, 1'b0);
    err_pend[0]++;
    wait_ready(0, n);
    check("busy_len_clr_a", 64'(n), 64'(DEPTH));
    rd(0, 10'd4, 8'h00);
    idle(0);

    // Read colliding with clr is dropped; the new sweep wipes address 100.
    wrt(0, 10'd100, 8'hAA);
    rd(0, 10'd100, 8'hAA);
    step(0, 1'b1, 1'b0, 10'd100, 8'h00, 1'b1);
    err_pend[0]++;
    wait_ready(0, n);
    check("busy_len_clr_b", 64'(n), 64'(DEPTH + 1));
    rd(0, 10'd100, 8'h00);
    idle(0);

    // Two-stage read pipeline with a non-zero clear value.
    @(negedge clk);
    rst[1] = 1'b0;
    wait_ready(1, n);
    check("busy_len_reset_b", 64'(n), 64'(DEPTH));
    rd(1, 10'd7, 8'h5A);
    rd(1, 10'd8, 8'h5A);
    rd(1, 10'd9, 8'h5A);
    wrt(1, 10'd8, 8'h33);
    rd(1, 10'd7, 8'h5A);
    rd(1, 10'd8, 8'h33);
    rd(1, 10'd9, 8'h5A);
    idle(1);
    repeat (4) @(negedge clk);

    // Reset lands while a read sits in the first pipeline stage; no response may follow.
    step(1, 1'b1, 1'b0, 10'd8, 8'h00, 1'b0);
    @(negedge clk);
    cs[1]  = 1'b0;
    rst[1] = 1'b1;
    #1;
    check("midread_rst_rd_valid", 64'(rd_valid[1]), 64'd0);
    check("midread_rst_data_out", 64'(dout[1]), 64'd0);
    check("midread_rst_busy", 64'(busy[1]), 64'd1);
    repeat (3) @(negedge clk);
    rst[1] = 1'b0;
    repeat (6) @(negedge clk);

    check("pending_reads_a", 64'(q_a.size()), 64'd0);
    check("pending_reads_b", 64'(q_b.size()), 64'd0);
    check("pending_err_a", 64'(err_pend[0]), 64'd0);
    check("pending_err_b", 64'(err_pend[1]), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
